// File: rtl/topk_select.sv
// topk_select: drains a programmed number of OFIFO rows and keeps a descending-sorted
// list of the k largest distance values together with their flat element indices.
// Optional build macro TOPK_SIGNED_EN: compare distances as two's-complement signed
// values (default: unsigned).
module topk_select #(
  parameter int unsigned psum_bw = 16,
  parameter int unsigned col     = 8,
  parameter int unsigned k       = 4,
  parameter int unsigned idx_bw  = 8,
  localparam int unsigned CntW   = $clog2(k + 1),
  localparam int unsigned JW     = (col > 1) ? $clog2(col) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [idx_bw-1:0]       num_rows,
  input  logic                    ofifo_valid,
  input  logic [psum_bw*col-1:0]  ofifo_rdata,
  output logic                    ofifo_rd,
  output logic                    busy,
  output logic                    done,
  output logic [psum_bw*k-1:0]    topk_dist,
  output logic [idx_bw*k-1:0]     topk_idx,
  output logic [CntW-1:0]         topk_cnt
);

  typedef enum logic [1:0] {StIdle, StFetch, StScan, StDone} state_e;

  state_e                   state_q;
  logic [psum_bw*col-1:0]   row_buf_q;
  logic [JW-1:0]            j_q;
  logic [idx_bw-1:0]        row_q;
  logic [idx_bw-1:0]        num_rows_q;
  logic [idx_bw-1:0]        elem_q;   // row*col + j, wraps at idx_bw bits
  logic [psum_bw-1:0]       dist_q [k];
  logic [idx_bw-1:0]        idx_q  [k];
  logic [CntW-1:0]          cnt_q;
  logic                     busy_q;
  logic                     done_q;

  logic [psum_bw-1:0]       cand;
  logic [k-1:0]             gt;
  logic [psum_bw-1:0]       ins_dist [k];
  logic [idx_bw-1:0]        ins_idx  [k];
  logic [CntW-1:0]          cnt_d;

  // Strict greater-than; ties keep the older entry ahead.
  function automatic logic cand_gt(input logic [psum_bw-1:0] a, input logic [psum_bw-1:0] b);
`ifdef TOPK_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Sorted insertion of the current candidate into the list.
  always_comb begin
    cand = row_buf_q[int'(j_q)*psum_bw +: psum_bw];
    for (int i = 0; i < k; i++) begin
      // The list is descending with empty slots at the bottom, so gt is thermometer-coded.
      gt[i] = (i >= int'(cnt_q)) || cand_gt(cand, dist_q[i]);
    end
    ins_dist[0] = gt[0] ? cand : dist_q[0];
    ins_idx[0]  = gt[0] ? elem_q : idx_q[0];
    for (int i = 1; i < k; i++) begin
      ins_dist[i] = dist_q[i];
      ins_idx[i]  = idx_q[i];
      if (gt[i]) begin
        if (gt[i-1]) begin
          ins_dist[i] = dist_q[i-1];
          ins_idx[i]  = idx_q[i-1];
        end else begin
          ins_dist[i] = cand;
          ins_idx[i]  = elem_q;
        end
      end
    end
    cnt_d = (cnt_q == CntW'(k)) ? cnt_q : cnt_q + CntW'(1);
  end

  // Control FSM, list registers and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      row_buf_q  <= '0;
      j_q        <= '0;
      row_q      <= '0;
      num_rows_q <= '0;
      elem_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < k; i++) begin
        dist_q[i] <= '0;
        idx_q[i]  <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            for (int i = 0; i < k; i++) begin
              dist_q[i] <= '0;
              idx_q[i]  <= '0;
            end
            cnt_q      <= '0;
            num_rows_q <= num_rows;
            row_q      <= '0;
            elem_q     <= '0;
            busy_q     <= 1'b1;
            if (num_rows == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StFetch;
            end
          end
        end
        StFetch: begin
          if (ofifo_valid) begin
            row_buf_q <= ofifo_rdata;
            j_q       <= '0;
            state_q   <= StScan;
          end
        end
        StScan: begin
          dist_q <= ins_dist;
          idx_q  <= ins_idx;
          cnt_q  <= cnt_d;
          elem_q <= elem_q + idx_bw'(1);
          j_q    <= j_q + JW'(1);
          if (j_q == JW'(col - 1)) begin
            row_q <= row_q + idx_bw'(1);
            if ((row_q + idx_bw'(1)) == num_rows_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StFetch;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Pop is combinational so a show-ahead row is taken on the first FETCH edge.
  always_comb begin
    ofifo_rd = (state_q == StFetch) && ofifo_valid;
    busy     = busy_q;
    done     = done_q;
    topk_cnt = cnt_q;
    for (int i = 0; i < k; i++) begin
      topk_dist[i*psum_bw +: psum_bw] = dist_q[i];
      topk_idx[i*idx_bw +: idx_bw]    = idx_q[i];
    end
  end

endmodule
